// File: rtl/fir_sym_ctrl.sv
// Sequencer for a folded symmetric FIR: flushes the delay line,
// writes each sample and issues tap-pair reads to the MAC datapath.
module fir_sym_ctrl #(
  parameter int TAPS     = 32,
  parameter int PIPE_LAT = 2,
  localparam int NPAIR  = (TAPS + 1) / 2,
  localparam int ADDR_W = $clog2(TAPS),
  localparam int COEF_W = (NPAIR > 1) ? $clog2(NPAIR) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              wr_en,
  output logic              wr_zero,
  output logic [ADDR_W-1:0] wr_addr,
  output logic              rd_valid,
  output logic [ADDR_W-1:0] rd_addr_a,
  output logic [ADDR_W-1:0] rd_addr_b,
  output logic [COEF_W-1:0] coef_idx,
  output logic              mid_tap,
  output logic              acc_clr,
  output logic              out_valid
);

  localparam int CNT_W = $clog2(TAPS + PIPE_LAT + 1);

  typedef enum logic [2:0] {
    FLUSH,
    IDLE,
    MAC,
    DRAIN,
    DONE
  } state_t;

  state_t            state;
  logic [CNT_W-1:0]  cnt;
  logic [ADDR_W-1:0] head;
  logic [ADDR_W-1:0] pa;
  logic [ADDR_W-1:0] pb;

  function automatic logic [ADDR_W-1:0] inc(
    input logic [ADDR_W-1:0] x
  );
    return (x == ADDR_W'(TAPS - 1)) ? '0 : x + ADDR_W'(1);
  endfunction

  function automatic logic [ADDR_W-1:0] dec(
    input logic [ADDR_W-1:0] x
  );
    return (x == '0) ? ADDR_W'(TAPS - 1) : x - ADDR_W'(1);
  endfunction

  // State machine; each edge registers the outputs for the coming cycle
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= FLUSH;
      cnt       <= '0;
      head      <= '0;
      pa        <= '0;
      pb        <= '0;
      in_ready  <= 1'b0;
      wr_en     <= 1'b0;
      wr_zero   <= 1'b0;
      wr_addr   <= '0;
      rd_valid  <= 1'b0;
      rd_addr_a <= '0;
      rd_addr_b <= '0;
      coef_idx  <= '0;
      mid_tap   <= 1'b0;
      acc_clr   <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      in_ready  <= 1'b0;
      wr_en     <= 1'b0;
      wr_zero   <= 1'b0;
      wr_addr   <= '0;
      rd_valid  <= 1'b0;
      rd_addr_a <= '0;
      rd_addr_b <= '0;
      coef_idx  <= '0;
      mid_tap   <= 1'b0;
      acc_clr   <= 1'b0;
      out_valid <= 1'b0;
      unique case (state)
        FLUSH: begin
          wr_en   <= 1'b1;
          wr_zero <= 1'b1;
          wr_addr <= ADDR_W'(cnt);
          if (cnt == CNT_W'(TAPS - 1)) begin
            cnt   <= '0;
            state <= IDLE;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        IDLE: begin
          if (in_ready && in_valid) begin
            wr_en   <= 1'b1;
            wr_addr <= head;
            pa      <= head;
            pb      <= inc(head);
            head    <= inc(head);
            cnt     <= '0;
            state   <= MAC;
          end else begin
            in_ready <= 1'b1;
          end
        end
        MAC: begin
          rd_valid  <= 1'b1;
          rd_addr_a <= pa;
          rd_addr_b <= pb;
          coef_idx  <= COEF_W'(cnt);
          acc_clr   <= (cnt == '0);
          mid_tap   <= (TAPS % 2 == 1) &&
                       (cnt == CNT_W'(NPAIR - 1));
          pa        <= dec(pa);
          pb        <= inc(pb);
          if (cnt == CNT_W'(NPAIR - 1)) begin
            cnt   <= '0;
            state <= (PIPE_LAT > 0) ? DRAIN : DONE;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        DRAIN: begin
          if (cnt == CNT_W'(PIPE_LAT - 1)) begin
            cnt   <= '0;
            state <= DONE;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        DONE: begin
          out_valid <= 1'b1;
          state     <= IDLE;
        end
        default: begin
          cnt   <= '0;
          state <= FLUSH;
        end
      endcase
    end
  end

endmodule
